// File: rtl/debug_link_pkg.sv
// -----------------------------------------------------------------------------
// debug_link_pkg
// Shared definitions for the debug link transmit path: the frame-engine /
// word-sequencer state enum, frame geometry and line levels.
// -----------------------------------------------------------------------------
package debug_link_pkg;

  // IDLE/START/DATA/STOP are used by the bit-level engine. The word
  // sequencer uses IDLE, DATA (word in flight) and DONE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int   BITS_PER_FRAME = 10;
  localparam int   BYTES_PER_WORD = 4;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

  // Fold one byte into a running XOR checksum.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Bit-level 8N1 frame engine: start bit, 8 data bits LSB first, stop bit,
// each bit CLKS_PER_BIT cycles long.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   byte_start in   load byte_data and begin a frame (taken in IDLE, or in the
//                   final cycle of a stop bit for zero-gap chaining)
//   byte_data  in   byte to send, sampled when byte_start is taken
//   byte_done  out  high during the final cycle of the stop bit
//   tx         out  serial line, driven from a flop, idles high
// -----------------------------------------------------------------------------
module uart_tx_byte
  import debug_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_start,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic       tx
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             tx_r;

  logic             bit_end_s;
  logic             byte_done_s;

  // Decode end of the current bit period and end of the stop bit.
  always_comb begin
    bit_end_s   = (baud_cnt_r == CNT_LAST);
    byte_done_s = (state_r == STOP) && bit_end_s;
  end

  // Frame engine: baud counter, bit index, data shifter and line flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= STOP_BIT;
    end else begin
      case (state_r)
        IDLE: begin
          baud_cnt_r <= '0;
          if (byte_start) begin
            state_r <= START;
            shift_r <= byte_data;
            tx_r    <= START_BIT;
          end
        end

        START: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            state_r    <= DATA;
            tx_r       <= shift_r[0];
            shift_r    <= {1'b0, shift_r[7:1]};
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
              tx_r    <= STOP_BIT;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            // A request on the last stop cycle starts the next frame with no
            // idle gap on the line.
            if (byte_start) begin
              state_r <= START;
              shift_r <= byte_data;
              tx_r    <= START_BIT;
            end else begin
              state_r <= IDLE;
              tx_r    <= STOP_BIT;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end

        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= '0;
          bit_idx_r  <= 3'd0;
          tx_r       <= STOP_BIT;
        end
      endcase
    end
  end

  assign byte_done = byte_done_s;
  assign tx        = tx_r;

endmodule

// File: rtl/debug_word_tx.sv
// -----------------------------------------------------------------------------
// debug_word_tx
// Transmit side of the debug link. Accepts a 32-bit word per data_start,
// sends it MSB byte first as back-to-back 8N1 frames and pulses data_ready
// for one cycle after the final stop bit.
//
// Build option: define DEBUG_WORD_TX_CHECKSUM_EN to append a fifth byte
// holding the XOR of the four data bytes.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   data[31:0]  in   word to send, sampled only on the accepting edge
//   data_start  in   request, accepted when idle
//   data_ready  out  one-cycle pulse when the word has been fully sent
//   busy        out  high from acceptance until data_ready
//   tx          out  serial line, idles high
// -----------------------------------------------------------------------------
module debug_word_tx
  import debug_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        data_start,
  output logic        data_ready,
  output logic        busy,
  output logic        tx
);

`ifdef DEBUG_WORD_TX_CHECKSUM_EN
  localparam int NUM_BYTES = BYTES_PER_WORD + 1;
`else
  localparam int NUM_BYTES = BYTES_PER_WORD;
`endif
  localparam int               IDX_W    = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  state_e           state_r;
  logic [31:0]      word_r;       // remaining data bytes, next one in [31:24]
  logic [IDX_W-1:0] byte_idx_r;   // index of the byte currently on the line
  logic             busy_r;
  logic             data_ready_r;
`ifdef DEBUG_WORD_TX_CHECKSUM_EN
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(BYTES_PER_WORD - 1);
  logic [7:0]       csum_r;
`endif

  logic             accept_s;
  logic             advance_s;
  logic             finish_s;
  logic             byte_start_s;
  logic [7:0]       byte_data_s;
  logic             byte_done_s;

  // Sequencing decisions: accept a new word, chain the next byte, or finish.
  always_comb begin
    accept_s    = 1'b0;
    advance_s   = 1'b0;
    finish_s    = 1'b0;
    byte_data_s = word_r[31:24];
    case (state_r)
      IDLE: begin
        if (data_start) begin
          accept_s    = 1'b1;
          byte_data_s = data[31:24];
        end else begin
          accept_s    = 1'b0;
        end
      end
      DATA: begin
        if (byte_done_s) begin
          if (byte_idx_r == IDX_LAST) begin
            finish_s  = 1'b1;
          end else begin
            advance_s = 1'b1;
`ifdef DEBUG_WORD_TX_CHECKSUM_EN
            if (byte_idx_r == IDX_LAST_DATA) begin
              byte_data_s = csum_r;
            end else begin
              byte_data_s = word_r[31:24];
            end
`endif
          end
        end else begin
          finish_s = 1'b0;
        end
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
    byte_start_s = accept_s | advance_s;
  end

  // Word sequencer: shift register, byte index, checksum, busy/data_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      word_r       <= 32'h0000_0000;
      byte_idx_r   <= '0;
      busy_r       <= 1'b0;
      data_ready_r <= 1'b0;
`ifdef DEBUG_WORD_TX_CHECKSUM_EN
      csum_r       <= 8'h00;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          data_ready_r <= 1'b0;
          if (accept_s) begin
            state_r    <= DATA;
            // Byte 0 goes straight to the engine; keep bytes 1..3.
            word_r     <= {data[23:0], 8'h00};
            byte_idx_r <= '0;
            busy_r     <= 1'b1;
`ifdef DEBUG_WORD_TX_CHECKSUM_EN
            csum_r     <= data[31:24];
`endif
          end
        end

        DATA: begin
          if (finish_s) begin
            state_r      <= DONE;
            busy_r       <= 1'b0;
            data_ready_r <= 1'b1;
          end else if (advance_s) begin
            byte_idx_r <= byte_idx_r + IDX_W'(1);
            word_r     <= {word_r[23:0], 8'h00};
`ifdef DEBUG_WORD_TX_CHECKSUM_EN
            csum_r     <= csum_fold(csum_r, word_r[31:24]);
`endif
          end
        end

        // One-cycle completion; a request seen here is dropped.
        DONE: begin
          state_r      <= IDLE;
          data_ready_r <= 1'b0;
        end

        default: begin
          state_r      <= IDLE;
          busy_r       <= 1'b0;
          data_ready_r <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .reset      (reset),
    .byte_start (byte_start_s),
    .byte_data  (byte_data_s),
    .byte_done  (byte_done_s),
    .tx         (tx)
  );

  assign busy       = busy_r;
  assign data_ready = data_ready_r;

endmodule

// File: tb/tb_debug_word_tx.sv
// -----------------------------------------------------------------------------
// tb_debug_word_tx
// Self-checking bench for debug_word_tx with CLKS_PER_BIT = 4. The expected
// line level for every cycle of a word is computed from the frame rules
// (word, cycle offset) -> bit; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_debug_word_tx;

  localparam int CPB = 4;
`ifdef DEBUG_WORD_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int TOTAL = 10 * NB * CPB;

  logic        clk;
  logic        reset;
  logic [31:0] data;
  logic        data_start;
  logic        data_ready;
  logic        busy;
  logic        tx;

  int n_checks = 0;
  int n_errors = 0;

  debug_word_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .data_start (data_start),
    .data_ready (data_ready),
    .busy       (busy),
    .tx         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Expected line level t cycles after the accepting edge.
  function automatic logic ref_tx(input logic [31:0] w, input int t);
    int bit_no;
    int byte_no;
    int pos;
    int b;
    bit_no  = t / CPB;
    byte_no = bit_no / 10;
    pos     = bit_no % 10;
    if (byte_no < 4) b = (w >> (8 * (3 - byte_no))) & 255;
    else             b = ((w >> 24) ^ (w >> 16) ^ (w >> 8) ^ w) & 255;
    if (pos == 0)      return 1'b0;
    else if (pos == 9) return 1'b1;
    else               return 1'((b >> (pos - 1)) & 1);
  endfunction

  // Caller is at a falling edge with the DUT idle.
  task automatic send_word(input logic [31:0] w, input int poke_at, input logic [31:0] poke_w,
                           input int reset_at, input bit done_poke);
    bit aborted;
    aborted    = 1'b0;
    data       = w;
    data_start = 1'b1;
    @(posedge clk);
    for (int t = 0; t <= TOTAL; t++) begin
      @(negedge clk);
      if (t < TOTAL) begin
        check("tx_bit", {31'd0, tx}, {31'd0, ref_tx(w, t)});
        check("busy_hi", {31'd0, busy}, 32'd1);
        check("ready_lo", {31'd0, data_ready}, 32'd0);
      end else begin
        check("ready_pulse", {31'd0, data_ready}, 32'd1);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("tx_done", {31'd0, tx}, 32'd1);
      end
      if (t == reset_at - 1) begin
        data_start = 1'b0;
        reset      = 1'b1;
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, data_ready}, 32'd0);
        repeat (3) begin
          @(negedge clk);
          check("rst_hold_tx", {31'd0, tx}, 32'd1);
          check("rst_hold_busy", {31'd0, busy}, 32'd0);
        end
        reset   = 1'b0;
        aborted = 1'b1;
        break;
      end else if (t == poke_at - 1) begin
        data_start = 1'b1;
        data       = poke_w;
      end else if (t == TOTAL && done_poke) begin
        data_start = 1'b1;
        data       = $urandom;
      end else begin
        data_start = 1'b0;
        data       = $urandom;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      check("post_ready_lo", {31'd0, data_ready}, 32'd0);
      check("post_busy_lo", {31'd0, busy}, 32'd0);
      check("post_tx_hi", {31'd0, tx}, 32'd1);
      data_start = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_tx"}, {31'd0, tx}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_ready"}, {31'd0, data_ready}, 32'd0);
      data = $urandom;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    int pk;
    int rs;
    reset      = 1'b1;
    data       = 32'h0;
    data_start = 1'b0;
    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, data_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_cycles(3, "start_idle");

    // Plain word, then the same word with an ignored mid-flight request.
    send_word(32'hDEADBEEF, -1, 32'h0, -1, 1'b0);
    send_word(32'hDEADBEEF, 50, 32'h12345678, -1, 1'b0);
    // Next request in the cycle right after data_ready.
    send_word(32'h00000001, -1, 32'h0, -1, 1'b0);
    // Request held during the DONE cycle must be dropped.
    send_word(32'hA5C30F96, -1, 32'h0, -1, 1'b1);
    idle_cycles(2, "after_done_poke");

    // Reset mid-frame, then a normal word.
    send_word(32'hDEADBEEF, -1, 32'h0, 70, 1'b0);
    idle_cycles(TOTAL + 5, "after_reset");
    send_word(32'hCAFEF00D, -1, 32'h0, -1, 1'b0);

    idle_cycles(1000, "long_idle");

    for (int k = 0; k < 6; k++) begin
      pk = (($urandom % 2) == 0) ? int'($urandom_range(2, TOTAL - 2)) : -1;
      rs = (k == 3) ? int'($urandom_range(2, TOTAL - 1)) : -1;
      send_word($urandom, pk, $urandom, rs, 1'($urandom % 2));
      if (rs > 0) idle_cycles(TOTAL + 2, "rand_after_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
